// File: rtl/uart_pkg.sv
// Shared types, constants and the baud divisor helper for the UART blocks.
// uart_div returns 0 when the requested rate cannot be met, so callers can refuse to elaborate.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE       = 8;
  localparam int UART_DATA_BITS        = 8;
  localparam int UART_SAMPLE_TICKS [3] = '{3, 4, 5};

  // Rounded clocks-per-tick; 0 means below one clock or more than 2 % rate error.
  function automatic int uart_div(input longint clk_freq, input longint baud);
    longint os;
    longint tol;
    longint d;
    longint actual;
    longint diff;
    os  = UART_OVERSAMPLE;
    tol = 50;
    if (baud <= 0 || clk_freq <= 0) return 0;
    d = (clk_freq + (baud * os) / 2) / (baud * os);
    if (d < 1) return 0;
    actual = d * baud * os;
    diff   = (clk_freq > actual) ? (clk_freq - actual) : (actual - clk_freq);
    if (diff * tol > actual) return 0;
    return int'(d);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling prescaler: one-cycle tick every DIV clocks, restarted from zero by clear.
// Shared between the receiver and the planned transmitter.
module uart_baud_tick #(
  parameter int DIV = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 with 8x oversampling and 3-sample majority vote, valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err status pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int DIV    = uart_div(CLK_FREQ, BAUD);
  localparam int TICK_W = $clog2(UART_OVERSAMPLE);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);

  if (DIV < 1) begin : g_div_check
    $fatal(1, "uart_rx: CLK_FREQ/BAUD gives no usable divisor");
  end

  logic              sync1;
  logic              rx_s;
  uart_rx_state_t    state;
  uart_rx_state_t    next_state;
  logic              clear_tick;
  logic              tick;
  logic [TICK_W-1:0] tick_idx;
  logic              samp_a;
  logic              samp_b;
  logic              majority;
  logic              decide;
  logic [BIT_W-1:0]  bit_idx;
  logic [7:0]        shift_reg;
  logic              bit_clr;
  logic              shift_en;
  logic              stop_ok;
  logic              stop_bad;
  logic              load;
  logic              drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // The prescaler only runs while a frame is being timed, so windows align to the start edge.
  assign clear_tick = (state == IDLE) || (state == BREAK);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clock(clock),
    .reset(reset),
    .clear(clear_tick),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset || clear_tick) begin
      tick_idx <= '0;
    end else if (tick) begin
      tick_idx <= tick_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (tick) begin
      if (tick_idx == TICK_W'(UART_SAMPLE_TICKS[0])) samp_a <= rx_s;
      if (tick_idx == TICK_W'(UART_SAMPLE_TICKS[1])) samp_b <= rx_s;
    end
  end

  assign majority = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign decide   = tick && (tick_idx == TICK_W'(UART_SAMPLE_TICKS[2]));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every timed state moves on at the mid-window decision, not at the end of the window.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (!rx_s) next_state = START;
      START:  if (decide) next_state = majority ? IDLE : DATA;
      DATA: begin
        if (decide && bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
      PARITY: if (decide) next_state = STOP;
      STOP:   if (decide) next_state = majority ? IDLE : BREAK;
      BREAK:  if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_chk;
  logic parity_bad;
`endif

  always_comb begin
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk  = 1'b0;
`endif
    case (state)
      START: bit_clr  = decide;
      DATA:  shift_en = decide;
`ifdef UART_RX_PARITY_EN
      PARITY: par_chk = decide;
`endif
      STOP: begin
        stop_ok  = decide && majority;
        stop_bad = decide && !majority;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (bit_clr) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      bit_idx   <= bit_idx + 1'b1;
      shift_reg <= {majority, shift_reg[7:1]};
    end
  end

  // A completed byte overwrites rx_data only if the previous one is gone or leaving this cycle.
  assign load = stop_ok && (!rx_valid || rx_ready);
  assign drop = stop_ok && rx_valid && !rx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      frame_err <= stop_bad;
      overrun   <= drop;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset || bit_clr) begin
      parity_bad <= 1'b0;
    end else if (par_chk) begin
      parity_bad <= ^{shift_reg, majority};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (stop_ok || stop_bad) && parity_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
